// File: rtl/deconv_weight_col_fifo_pkg.sv
// -----------------------------------------------------------------------------
// deconv_weight_col_fifo_pkg
//   Shared definitions for the weight-column FIFO slice: lane count, the
//   priming FSM encodings and a helper that locates one lane's column inside
//   the packed multi-lane output bus.
//   No ports (package).
// -----------------------------------------------------------------------------
package deconv_weight_col_fifo_pkg;

  // One lane per deconv sub-core; the consumer side is built for exactly four.
  localparam int N_LANE = 4;

  typedef enum logic [1:0] {
    WF_FILL  = 2'd0,  // waiting until every lane holds a full kernel
    WF_PRIME = 2'd1,  // core_init issued, waiting for all output regs valid
    WF_RUN   = 2'd2   // kernels in use, waiting for every lane to release
  } wf_state_e;

  // LSB position of lane 'lane' in a bus of col_w-bit lane slices.
  function automatic int lane_lsb(input int lane, input int col_w);
    return lane * col_w;
  endfunction

endpackage

// File: rtl/deconv_wcol_lane.sv
// -----------------------------------------------------------------------------
// deconv_wcol_lane
//   One lane of the weight-column store. Columns are written in order,
//   popped in order into a registered output, and can be replayed from the
//   start of the current kernel (loop) or released up to the read point
//   (flush).
//   Three pointers, each one bit wider than the address so full and empty
//   are distinguishable:
//     wr_ptr   next free slot
//     rd_ptr   next column to pop
//     base_ptr first column of the kernel still held for replay
//   Ports:
//     i_clk, i_rst_n   clock, async active-low reset
//     i_wr_en          store i_wr_col at wr_ptr (caller guarantees not full)
//     i_wr_col         column to store
//     i_rd_en          pop request (ignored when nothing is available)
//     i_loop           rewind rd_ptr to base_ptr
//     i_flush          release everything before rd_ptr, clear out valid
//     o_col, o_valid   registered output column and its valid flag
//     o_occ            entries held (wr - base)
//     o_avail          entries still to pop (wr - rd)
// -----------------------------------------------------------------------------
module deconv_wcol_lane #(
  parameter int COL_W = 48,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [COL_W-1:0] i_wr_col,
  input  logic             i_rd_en,
  input  logic             i_loop,
  input  logic             i_flush,
  output logic [COL_W-1:0] o_col,
  output logic             o_valid,
  output logic [AW:0]      o_occ,
  output logic [AW:0]      o_avail
);

  logic [COL_W-1:0] mem [DEPTH];

  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      base_ptr_reg, base_ptr_next;
  logic [AW:0]      rd_ptr_adv;
  logic [COL_W-1:0] col_reg;
  logic             valid_reg, valid_next;
  logic             pop;

  assign o_occ   = wr_ptr_reg - base_ptr_reg;
  assign o_avail = wr_ptr_reg - rd_ptr_reg;
  assign pop     = i_rd_en && (o_avail != '0);

  always_comb begin
    rd_ptr_adv    = rd_ptr_reg + {{AW{1'b0}}, pop};
    wr_ptr_next   = wr_ptr_reg + {{AW{1'b0}}, i_wr_en};
    rd_ptr_next   = rd_ptr_adv;
    base_ptr_next = base_ptr_reg;
    valid_next    = valid_reg | pop;
    if (i_flush) begin
      // Release up to the read point including a same-cycle pop; a
      // simultaneous loop is ignored so rd_ptr simply keeps advancing.
      base_ptr_next = rd_ptr_adv;
      valid_next    = 1'b0;
    end else if (i_loop) begin
      // Loop owns the pointer even when a pop lands in the output this cycle.
      rd_ptr_next = base_ptr_reg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      base_ptr_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      base_ptr_reg <= base_ptr_next;
      valid_reg    <= valid_next;
    end
  end

  // Storage array carries no reset; pointer reset alone discards its contents.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= i_wr_col;
    end
  end

  // Registered read. A pop needs avail > 0, so rd never equals wr here and a
  // same-cycle write cannot collide with the read address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_reg <= '0;
    end else if (pop) begin
      col_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  assign o_col   = col_reg;
  assign o_valid = valid_reg;

endmodule

// File: rtl/deconv_weight_col_fifo.sv
// -----------------------------------------------------------------------------
// deconv_weight_col_fifo
//   Weight-column store between the weight BRAM reader and the four deconv
//   sub-cores. Whole kernel columns are written into one of four lanes; each
//   lane presents one registered column. Kernels can be replayed (loop) and
//   released (flush) per lane. A small FSM pulses o_core_init once every lane
//   holds a full kernel, then waits for all lanes to release before priming
//   again.
//   Optional build macro WCOL_FIFO_STATS_EN adds sticky error flags and a
//   successful-pop counter; the datapath is identical either way.
//   Ports:
//     i_clk, i_rst_n   clock, async active-low reset
//     i_wr_valid       write column valid
//     o_wr_ready       selected lane (i_wr_lane) has a free entry
//     i_wr_lane        target lane of the write
//     i_wr_col         column, pixel 0 in LSBs
//     i_rd_en[3:0]     per-lane pop
//     i_loop[3:0]      per-lane rewind to kernel base
//     i_flush[3:0]     per-lane release of the consumed kernel
//     o_weight_out     lane i at [i*COL_W +: COL_W]
//     o_export_done    all four output registers valid
//     o_core_init      one-cycle pulse when the first kernel is primed
//     o_err[1:0]       (stats) bit0 pop on empty lane, bit1 write while !ready
//     o_pop_cnt[31:0]  (stats) total successful pops
// -----------------------------------------------------------------------------
module deconv_weight_col_fifo
  import deconv_weight_col_fifo_pkg::*;
#(
  parameter int PIX_WIDTH      = 16,
  parameter int SIZE_OF_WEIGHT = 3,
  parameter int DEPTH          = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_wr_valid,
  output logic                                    o_wr_ready,
  input  logic [1:0]                              i_wr_lane,
  input  logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]     i_wr_col,
  input  logic [N_LANE-1:0]                       i_rd_en,
  input  logic [N_LANE-1:0]                       i_loop,
  input  logic [N_LANE-1:0]                       i_flush,
  output logic [PIX_WIDTH*SIZE_OF_WEIGHT*N_LANE-1:0] o_weight_out,
  output logic                                    o_export_done,
  output logic                                    o_core_init
`ifdef WCOL_FIFO_STATS_EN
  ,
  output logic [1:0]                              o_err,
  output logic [31:0]                             o_pop_cnt
`endif
);

  localparam int          COL_W    = PIX_WIDTH * SIZE_OF_WEIGHT;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] K_COLS   = (AW+1)'(SIZE_OF_WEIGHT);

  logic [AW:0]       occ   [N_LANE];
  logic [AW:0]       avail [N_LANE];
  logic [N_LANE-1:0] lane_wr;
  logic [N_LANE-1:0] out_valid;
  logic [N_LANE-1:0] lane_primed;
  logic              wr_fire;

  wf_state_e         state_reg, state_next;
  logic [N_LANE-1:0] flushed_reg, flushed_next;

  // Ready looks at the pre-update occupancy: a same-cycle flush does not
  // hand back credit until the following cycle.
  assign o_wr_ready    = (occ[i_wr_lane] != FULL_OCC);
  assign wr_fire       = i_wr_valid && o_wr_ready;
  assign o_export_done = &out_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_LANE; gi++) begin : g_lane
      assign lane_wr[gi]     = wr_fire && (i_wr_lane == 2'(gi));
      assign lane_primed[gi] = (avail[gi] >= K_COLS);

      deconv_wcol_lane #(
        .COL_W (COL_W),
        .DEPTH (DEPTH),
        .AW    (AW)
      ) u_lane (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr_en  (lane_wr[gi]),
        .i_wr_col (i_wr_col),
        .i_rd_en  (i_rd_en[gi]),
        .i_loop   (i_loop[gi]),
        .i_flush  (i_flush[gi]),
        .o_col    (o_weight_out[lane_lsb(gi, COL_W) +: COL_W]),
        .o_valid  (out_valid[gi]),
        .o_occ    (occ[gi]),
        .o_avail  (avail[gi])
      );
    end
  endgenerate

  // Priming FSM
  always_comb begin
    state_next   = state_reg;
    flushed_next = flushed_reg;
    o_core_init  = 1'b0;
    case (state_reg)
      WF_FILL: begin
        if (&lane_primed) begin
          o_core_init = 1'b1;
          state_next  = WF_PRIME;
        end
      end
      WF_PRIME: begin
        if (o_export_done) begin
          state_next = WF_RUN;
        end
      end
      WF_RUN: begin
        // Lanes may release their kernels in any order over many cycles.
        flushed_next = flushed_reg | i_flush;
        if (&flushed_next) begin
          flushed_next = '0;
          state_next   = WF_FILL;
        end
      end
      default: begin
        state_next = WF_FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= WF_FILL;
      flushed_reg <= '0;
    end else begin
      state_reg   <= state_next;
      flushed_reg <= flushed_next;
    end
  end

`ifdef WCOL_FIFO_STATS_EN
  logic [N_LANE-1:0] lane_nonempty;
  logic [N_LANE-1:0] lane_pop;
  logic [2:0]        pop_sum;
  logic [1:0]        err_reg;
  logic [31:0]       pop_cnt_reg;

  generate
    for (gi = 0; gi < N_LANE; gi++) begin : g_stat
      assign lane_nonempty[gi] = (avail[gi] != '0);
    end
  endgenerate

  assign lane_pop = i_rd_en & lane_nonempty;

  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < N_LANE; i++) begin
      pop_sum = pop_sum + {2'b00, lane_pop[i]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_reg     <= '0;
      pop_cnt_reg <= '0;
    end else begin
      err_reg     <= err_reg | {i_wr_valid && !o_wr_ready,
                                |(i_rd_en & ~lane_nonempty)};
      pop_cnt_reg <= pop_cnt_reg + 32'(pop_sum);
    end
  end

  assign o_err     = err_reg;
  assign o_pop_cnt = pop_cnt_reg;
`endif

endmodule

// File: tb/tb_deconv_weight_col_fifo.sv
`timescale 1ns/1ps
module tb_deconv_weight_col_fifo;

  localparam int PW    = 16;
  localparam int K     = 3;
  localparam int COL_W = PW * K;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_wr_valid = 1'b0;
  logic [1:0]           i_wr_lane = '0;
  logic [COL_W-1:0]     i_wr_col = '0;
  logic [3:0]           i_rd_en = '0;
  logic [3:0]           i_loop = '0;
  logic [3:0]           i_flush = '0;
  logic                 o_wr_ready;
  logic [4*COL_W-1:0]   o_weight_out;
  logic                 o_export_done;
  logic                 o_core_init;
`ifdef WCOL_FIFO_STATS_EN
  logic [1:0]           o_err;
  logic [31:0]          o_pop_cnt;
`endif

  always #5 i_clk = ~i_clk;

  deconv_weight_col_fifo #(
    .PIX_WIDTH      (PW),
    .SIZE_OF_WEIGHT (K),
    .DEPTH          (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .i_wr_lane     (i_wr_lane),
    .i_wr_col      (i_wr_col),
    .i_rd_en       (i_rd_en),
    .i_loop        (i_loop),
    .i_flush       (i_flush),
    .o_weight_out  (o_weight_out),
    .o_export_done (o_export_done),
    .o_core_init   (o_core_init)
`ifdef WCOL_FIFO_STATS_EN
    ,
    .o_err         (o_err),
    .o_pop_cnt     (o_pop_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int init_cnt = 0;
  int exp_pops = 0;

  // Counts cycles with o_core_init high; a clean pulse adds exactly one.
  always @(negedge i_clk) if (o_core_init === 1'b1) init_cnt++;

  typedef struct {
    int               lane;
    logic [COL_W-1:0] col;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic rd;
    logic lp;
    int   exp_j;
    logic exp_export;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [COL_W-1:0] col(input int lane, input int j);
    logic [COL_W-1:0] c;
    for (int p = 0; p < K; p++) c[p*PW +: PW] = {4'(lane), 4'(j), 4'(p), 4'h0};
    return c;
  endfunction

  function automatic logic [COL_W-1:0] lane_out(input int lane);
    return o_weight_out[lane*COL_W +: COL_W];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic expect_col(input int lane, input int j, input bit counted);
    sb_t e;
    e.lane = lane;
    e.col  = col(lane, j);
    sb_q.push_back(e);
    if (counted) exp_pops++;
  endtask

  task automatic cycle(input logic [3:0] rd, input logic [3:0] lp, input logic [3:0] fl);
    sb_t e;
    i_rd_en = rd; i_loop = lp; i_flush = fl;
    @(posedge i_clk); #1;
    i_rd_en = '0; i_loop = '0; i_flush = '0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("lane%0d_out", e.lane), 64'(lane_out(e.lane)), 64'(e.col));
    end
  endtask

  task automatic write_col(input int lane, input int j, input logic exp_ready);
    i_wr_valid = 1'b1; i_wr_lane = 2'(lane); i_wr_col = col(lane, j);
    #1 check($sformatf("wr_ready_l%0d_c%0d", lane, j), 64'(o_wr_ready), 64'(exp_ready));
    @(posedge i_clk); #1;
    i_wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // lane0 pop/loop vectors; lane0 starts with col0 already popped, 3 stored
    tbl[0] = '{rd: 1'b1, lp: 1'b0, exp_j: 1, exp_export: 1'b1};
    tbl[1] = '{rd: 1'b1, lp: 1'b1, exp_j: 2, exp_export: 1'b1}; // pop+loop: out col2, rd->base
    tbl[2] = '{rd: 1'b1, lp: 1'b0, exp_j: 0, exp_export: 1'b1}; // replay starts at col0
    tbl[3] = '{rd: 1'b1, lp: 1'b0, exp_j: 1, exp_export: 1'b1};
    tbl[4] = '{rd: 1'b0, lp: 1'b1, exp_j: 1, exp_export: 1'b1}; // loop alone: out held
    tbl[5] = '{rd: 1'b1, lp: 1'b0, exp_j: 0, exp_export: 1'b1};
    tbl[6] = '{rd: 1'b1, lp: 1'b0, exp_j: 1, exp_export: 1'b1};
    tbl[7] = '{rd: 1'b1, lp: 1'b0, exp_j: 2, exp_export: 1'b1};
    tbl[8] = '{rd: 1'b0, lp: 1'b1, exp_j: 2, exp_export: 1'b1};

    // Reset
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("rst_wr_ready", 64'(o_wr_ready), 64'd1);
    check("rst_export_done", 64'(o_export_done), 64'd0);
    check("rst_weight_zero", 64'(o_weight_out == '0), 64'd1);
    check("rst_core_init_cnt", 64'(init_cnt), 64'd0);

    // Fill 3 columns per lane
    for (int l = 0; l < 4; l++) begin
      for (int j = 0; j < K; j++) begin
        if (l == 3 && j == K-1) check("no_init_before_full", 64'(init_cnt), 64'd0);
        write_col(l, j, 1'b1);
      end
    end
    repeat (3) @(posedge i_clk); #1;
    check("core_init_single_pulse", 64'(init_cnt), 64'd1);

    // Pop all lanes
    for (int l = 0; l < 4; l++) expect_col(l, 0, 1'b1);
    cycle(4'hF, 4'h0, 4'h0);
    check("export_done_after_pop", 64'(o_export_done), 64'd1);

    // Lane0 pop/loop table
    for (int r = 0; r < 9; r++) begin
      expect_col(0, tbl[r].exp_j, tbl[r].rd);
      cycle({3'b000, tbl[r].rd}, {3'b000, tbl[r].lp}, 4'h0);
      check($sformatf("tbl%0d_export", r), 64'(o_export_done), 64'(tbl[r].exp_export));
    end

    // Lane0 to full, then free 3 with flush
    for (int j = 3; j < 8; j++) write_col(0, j, 1'b1);
    i_wr_lane = 2'd0;
    #1 check("l0_full_ready", 64'(o_wr_ready), 64'd0);
    for (int j = 0; j < 3; j++) begin
      expect_col(0, j, 1'b1);
      cycle(4'h1, 4'h0, 4'h0);
    end
    expect_col(0, 2, 1'b0);
    cycle(4'h0, 4'h0, 4'h1);
    check("flush_export_done", 64'(o_export_done), 64'd0);
    i_wr_lane = 2'd0;
    #1 check("l0_ready_after_flush", 64'(o_wr_ready), 64'd1);
    expect_col(0, 3, 1'b1);
    cycle(4'h1, 4'h0, 4'h0);
    check("export_after_repop", 64'(o_export_done), 64'd1);
    // Flush and loop together: flush wins, read point stays after col3
    expect_col(0, 3, 1'b0);
    cycle(4'h0, 4'h1, 4'h1);
    expect_col(0, 4, 1'b1);
    cycle(4'h1, 4'h0, 4'h0);

    // Lane1 to full; forced 9th write must be dropped
    for (int j = 3; j < 8; j++) write_col(1, j, 1'b1);
    i_wr_valid = 1'b1; i_wr_lane = 2'd1; i_wr_col = col(1, 8);
    #1 check("l1_full_ready", 64'(o_wr_ready), 64'd0);
    @(posedge i_clk); #1;
    i_wr_valid = 1'b0;
`ifdef WCOL_FIFO_STATS_EN
    check("err_after_overflow", 64'(o_err), 64'd2);
`endif
    expect_col(1, 1, 1'b1);
    cycle(4'h2, 4'h2, 4'h0);
    expect_col(1, 0, 1'b1);   // slot 0 must not hold the dropped column
    cycle(4'h2, 4'h0, 4'h0);

    // Lane3 drained, then popped while empty
    expect_col(3, 1, 1'b1);
    cycle(4'h8, 4'h0, 4'h0);
    expect_col(3, 2, 1'b1);
    cycle(4'h8, 4'h0, 4'h0);
    expect_col(3, 2, 1'b0);
    cycle(4'h8, 4'h0, 4'h0);
    check("export_after_underflow", 64'(o_export_done), 64'd1);
`ifdef WCOL_FIFO_STATS_EN
    check("err_after_underflow", 64'(o_err), 64'd3);
    check("pop_cnt", 64'(o_pop_cnt), 64'(exp_pops));
`endif

    // Asynchronous reset in the middle of RUN
    i_wr_lane = 2'd1;
    #3 i_rst_n = 1'b0;
    #1;
    check("midrst_wr_ready", 64'(o_wr_ready), 64'd1);
    check("midrst_export_done", 64'(o_export_done), 64'd0);
    check("midrst_weight_zero", 64'(o_weight_out == '0), 64'd1);
    check("midrst_core_init", 64'(o_core_init), 64'd0);
`ifdef WCOL_FIFO_STATS_EN
    check("midrst_err", 64'(o_err), 64'd0);
    check("midrst_pop_cnt", 64'(o_pop_cnt), 64'd0);
`endif
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    cycle(4'h2, 4'h0, 4'h0);
    check("post_rst_pop_empty", 64'(o_weight_out == '0), 64'd1);
    check("post_rst_export", 64'(o_export_done), 64'd0);
    check("post_rst_no_init", 64'(init_cnt), 64'd1);

    // Refill after reset primes again from a clean state
    for (int l = 0; l < 4; l++) begin
      for (int j = 0; j < K; j++) write_col(l, j + 4, 1'b1);
    end
    repeat (2) @(posedge i_clk); #1;
    check("core_init_after_refill", 64'(init_cnt), 64'd2);
    expect_col(2, 4, 1'b1);
    cycle(4'h4, 4'h0, 4'h0);
    check("refill_export_partial", 64'(o_export_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
